// File: rtl/vga_timing_pkg.sv
// Timing constants and colour helpers for the 640x480@60 VGA output stage.
// Optional feature macro: VGA_COLOR_BARS_EN (colour-bar test pattern).
package vga_timing_pkg;

  // Default 640x480@60 timing, in pixel ticks (horizontal) and lines (vertical)
  localparam int PIX_DIV_DEF  = 2;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam logic SYNC_POL_DEF = 1'b0;

  // Derived frame geometry and sync windows for the default timing
  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  // RGB332 byte layout {R[2:0],G[2:0],B[1:0]}
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_LSB = 0;

`ifdef VGA_COLOR_BARS_EN
  // Eight 80-pixel bars; bar index bits select full-scale R, G and B
  function automatic logic [7:0] bar_colour(input logic [9:0] x);
    logic [9:0] bar;
    bar = x / 10'd80;
    return {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
  endfunction
`endif

endpackage

// File: rtl/vga_sync_salida_if.sv
// Colour input and DAC/sync/coordinate outputs of the VGA output stage.
interface vga_sync_salida_if;
  logic [7:0] colores_in;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       frame_start;

  modport master (
    input  colores_in,
    output hsync, vsync, red, green, blue, pixel_x, pixel_y, video_on, frame_start
  );

  modport slave (
    output colores_in,
    input  hsync, vsync, red, green, blue, pixel_x, pixel_y, video_on, frame_start
  );
endinterface

// File: rtl/vga_pixel_tick.sv
// Divides the board clock down to the pixel rate: tick is high on the last
// clock of every PIX_DIV-clock period (every clock when PIX_DIV = 1).
module vga_pixel_tick #(
  parameter int PIX_DIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam logic [2:0] DIV_LAST = 3'(PIX_DIV - 1);

  logic [2:0] div_q;
  logic [2:0] div_d;

  assign tick = (div_q == DIV_LAST);

  // Divider next value: wrap on the tick clock, otherwise count up
  always_comb begin
    div_d = div_q;
    if (tick) begin
      div_d = 3'd0;
    end else begin
      div_d = div_q + 3'd1;
    end
  end

  // Divider register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= 3'd0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_sync_salida.sv
// VGA timing generator and pixel output stage. Counts pixels/lines on the
// pixel tick, decodes sync windows and blanking, and registers all outputs
// one tick after the counter state they describe.
// Optional feature macro: VGA_COLOR_BARS_EN replaces colores_in with bars.
module vga_sync_salida
  import vga_timing_pkg::*;
#(
  parameter int   PIX_DIV  = PIX_DIV_DEF,
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  vga_sync_salida_if.master  bus
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       tick_s;
  logic       active_s;
  logic       hs_win_s;
  logic       vs_win_s;
  logic [7:0] colour_s;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [2:0] red_q, red_d;
  logic [2:0] green_q, green_d;
  logic [1:0] blue_q, blue_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;

  vga_pixel_tick #(.PIX_DIV(PIX_DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick_s)
  );

`ifdef VGA_COLOR_BARS_EN
  assign colour_s = bar_colour(h_cnt_q);
`else
  assign colour_s = bus.colores_in;
`endif

  assign active_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_win_s = (h_cnt_q >= HS_START) && (h_cnt_q <= HS_END);
  assign vs_win_s = (v_cnt_q >= VS_START) && (v_cnt_q <= VS_END);

  // Pixel/line counters: advance on tick, line steps when the pixel count wraps
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick_s) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q;
    end
  end

  // Output decode from the pre-increment counters; everything holds between ticks
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    video_on_d    = video_on_q;
    frame_start_d = 1'b0;
    if (tick_s) begin
      hsync_d       = hs_win_s ? SYNC_POL : ~SYNC_POL;
      vsync_d       = vs_win_s ? SYNC_POL : ~SYNC_POL;
      pixel_x_d     = h_cnt_q;
      pixel_y_d     = v_cnt_q;
      video_on_d    = active_s;
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      if (active_s) begin
        red_d   = colour_s[RGB_R_LSB +: 3];
        green_d = colour_s[RGB_G_LSB +: 3];
        blue_d  = colour_s[RGB_B_LSB +: 2];
      end else begin
        red_d   = 3'd0;
        green_d = 3'd0;
        blue_d  = 2'd0;
      end
    end else begin
      frame_start_d = 1'b0;
    end
  end

  // Counter and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      red_q         <= 3'd0;
      green_q       <= 3'd0;
      blue_q        <= 2'd0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 10'd0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.red         = red_q;
  assign bus.green       = green_q;
  assign bus.blue        = blue_q;
  assign bus.pixel_x     = pixel_x_q;
  assign bus.pixel_y     = pixel_y_q;
  assign bus.video_on    = video_on_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_salida.sv
// Bench for vga_sync_salida: a full-size 640x480 instance (PIX_DIV=2) and a
// shrunken instance (PIX_DIV=3, 15x9 frame, active-high sync) so that
// vertical timing and frame pulses fit in a short run.
module tb_vga_sync_salida;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
    logic [9:0] px;
    logic [9:0] py;
    logic       von;
    logic       fs;
  } out_t;

  typedef struct packed {
    int   div;
    int   ha;
    int   ht;
    int   hs0;
    int   hs1;
    int   va;
    int   vt;
    int   vs0;
    int   vs1;
    logic pol;
  } cfg_t;

  typedef struct packed {
    logic [63:0] name;
    int          dut;
    int          sig;
    int          kind;
    int          exp;
  } vec_t;

  localparam int SIG_HS  = 0;
  localparam int SIG_VS  = 1;
  localparam int SIG_VON = 2;
  localparam int SIG_FS  = 3;
  localparam int K_RUN   = 0;
  localparam int K_PER   = 1;
  localparam int LIMIT   = 5000;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  int         total   = 0;
  int         bad     = 0;
  int         cmode   = 2;
  logic [7:0] cconst  = 8'h00;

  logic [9:0] mh   [2];
  logic [9:0] mv   [2];
  int         mdiv [2];
  out_t       mexp [2];
  out_t       q0[$];
  out_t       q1[$];

  vga_sync_salida_if bus0 ();
  vga_sync_salida_if bus1 ();

  vga_sync_salida dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  vga_sync_salida #(
    .PIX_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  always #5 clock = ~clock;

  function automatic cfg_t cfg_of(input int d);
    cfg_t c;
    if (d == 0) c = '{2, 640, 800, 656, 751, 480, 525, 490, 491, 1'b0};
    else        c = '{3, 8, 15, 10, 12, 4, 9, 5, 6, 1'b1};
    return c;
  endfunction

  function automatic out_t read_out(input int d);
    out_t o;
    if (d == 0) begin
      o.hs = bus0.hsync; o.vs = bus0.vsync; o.rgb = {bus0.red, bus0.green, bus0.blue};
      o.px = bus0.pixel_x; o.py = bus0.pixel_y; o.von = bus0.video_on; o.fs = bus0.frame_start;
    end else begin
      o.hs = bus1.hsync; o.vs = bus1.vsync; o.rgb = {bus1.red, bus1.green, bus1.blue};
      o.px = bus1.pixel_x; o.py = bus1.pixel_y; o.von = bus1.video_on; o.fs = bus1.frame_start;
    end
    return o;
  endfunction

  function automatic logic asserted(input int d, input int sig);
    out_t o;
    cfg_t c;
    o = read_out(d);
    c = cfg_of(d);
    case (sig)
      SIG_HS:  return o.hs == c.pol;
      SIG_VS:  return o.vs == c.pol;
      SIG_VON: return o.von;
      default: return o.fs;
    endcase
  endfunction

  task automatic check_out(input logic [63:0] nm, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got hs=%0b vs=%0b rgb=%02h x=%0d y=%0d von=%0b fs=%0b, want hs=%0b vs=%0b rgb=%02h x=%0d y=%0d von=%0b fs=%0b",
               nm, act.hs, act.vs, act.rgb, act.px, act.py, act.von, act.fs,
               exp.hs, exp.vs, exp.rgb, exp.px, exp.py, exp.von, exp.fs);
    end
  endtask

  task automatic check_int(input logic [63:0] nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Scoreboard step for one instance: compare what the last clock produced,
  // drive the next colour, and predict what the coming clock edge registers.
  task automatic sb_step(input int d);
    cfg_t       c;
    out_t       e;
    out_t       act;
    logic [7:0] cin;
    logic [7:0] col;
    logic       tk;
`ifdef VGA_COLOR_BARS_EN
    logic [9:0] k;
`endif
    c   = cfg_of(d);
    act = read_out(d);
    if (!reset_n) begin
      e    = '0;
      e.hs = ~c.pol;
      e.vs = ~c.pol;
      check_out((d == 0) ? "reset__0" : "reset__1", act, e);
      if (d == 0) q0.delete(); else q1.delete();
      mdiv[d] = 0;
      mh[d]   = 10'd0;
      mv[d]   = 10'd0;
      mexp[d] = e;
    end else begin
      if (d == 0) begin
        if (q0.size() > 0) begin e = q0.pop_front(); check_out("sb_dut_0", act, e); end
      end else begin
        if (q1.size() > 0) begin e = q1.pop_front(); check_out("sb_dut_1", act, e); end
      end
    end
    case (cmode)
      0:       cin = cconst;
      1:       cin = mh[d][7:0];
      default: cin = 8'($urandom);
    endcase
    if (d == 0) bus0.colores_in = cin; else bus1.colores_in = cin;
    if (reset_n) begin
      e    = mexp[d];
      e.fs = 1'b0;
      tk   = (mdiv[d] == c.div - 1);
      if (tk) begin
        e.px  = mh[d];
        e.py  = mv[d];
        e.von = (int'(mh[d]) < c.ha) && (int'(mv[d]) < c.va);
        e.hs  = (int'(mh[d]) >= c.hs0 && int'(mh[d]) <= c.hs1) ? c.pol : ~c.pol;
        e.vs  = (int'(mv[d]) >= c.vs0 && int'(mv[d]) <= c.vs1) ? c.pol : ~c.pol;
`ifdef VGA_COLOR_BARS_EN
        k   = mh[d] / 10'd80;
        col = {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
`else
        col = cin;
`endif
        e.rgb = e.von ? col : 8'h00;
        e.fs  = (mh[d] == 10'd0) && (mv[d] == 10'd0);
        if (int'(mh[d]) == c.ht - 1) begin
          mh[d] = 10'd0;
          if (int'(mv[d]) == c.vt - 1) mv[d] = 10'd0;
          else                         mv[d] = mv[d] + 10'd1;
        end else begin
          mh[d] = mh[d] + 10'd1;
        end
        mdiv[d] = 0;
      end else begin
        mdiv[d] = mdiv[d] + 1;
      end
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      mexp[d] = e;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      sb_step(0);
      sb_step(1);
    end
  end

  // Run length (clocks asserted) or period (clocks between rising edges) of a signal
  task automatic measure(input int d, input int sig, input int kind, output int res);
    logic prev, cur, found;
    int   n, cnt;
    res   = -1;
    found = 1'b0;
    n     = 0;
    prev  = asserted(d, sig);
    cur   = prev;
    while (!found && n < LIMIT) begin
      @(negedge clock);
      cur = asserted(d, sig);
      if (cur && !prev) found = 1'b1;
      prev = cur;
      n++;
    end
    if (found) begin
      n     = 0;
      found = 1'b0;
      if (kind == K_RUN) begin
        cnt = 1;
        while (!found && n < LIMIT) begin
          @(negedge clock);
          if (asserted(d, sig)) cnt++; else found = 1'b1;
          n++;
        end
      end else begin
        cnt = 0;
        while (!found && n < LIMIT) begin
          @(negedge clock);
          cnt++;
          cur = asserted(d, sig);
          if (cur && !prev) found = 1'b1;
          prev = cur;
          n++;
        end
      end
      if (found) res = cnt;
    end
  endtask

  // Clocks from now until each instance shows frame_start
  task automatic first_fs(output int f0, output int f1);
    f0 = -1;
    f1 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (bus0.frame_start && f0 < 0) f0 = i;
      if (bus1.frame_start && f1 < 0) f1 = i;
    end
  endtask

  task automatic wait_px(input logic [9:0] x, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < LIMIT && !ok; i++) begin
      @(negedge clock);
      if (bus0.pixel_x == x) ok = 1'b1;
    end
    if (!ok) check_int("tmo_wait", 0, 1);
  endtask

  initial begin
    vec_t vecs [10];
    int   res, f0, f1;
    logic ok;

    vecs[0] = '{"hs_run_0", 0, SIG_HS,  K_RUN, 192};
    vecs[1] = '{"hs_per_0", 0, SIG_HS,  K_PER, 1600};
    vecs[2] = '{"von_rn_0", 0, SIG_VON, K_RUN, 1280};
    vecs[3] = '{"hs_run_1", 1, SIG_HS,  K_RUN, 9};
    vecs[4] = '{"hs_per_1", 1, SIG_HS,  K_PER, 45};
    vecs[5] = '{"vs_run_1", 1, SIG_VS,  K_RUN, 90};
    vecs[6] = '{"vs_per_1", 1, SIG_VS,  K_PER, 405};
    vecs[7] = '{"fs_per_1", 1, SIG_FS,  K_PER, 405};
    vecs[8] = '{"fs_run_1", 1, SIG_FS,  K_RUN, 1};
    vecs[9] = '{"von_rn_1", 1, SIG_VON, K_RUN, 24};

    // Power-up reset, then first frame pulse PIX_DIV+1 sampled clocks after release
    cmode   = 2;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    first_fs(f0, f1);
    check_int("fs_frst0", f0, 3);
    check_int("fs_frst1", f1, 4);

    // Timing measurements
    for (int i = 0; i < 10; i++) begin
      measure(vecs[i].dut, vecs[i].sig, vecs[i].kind, res);
      check_int(vecs[i].name, res, vecs[i].exp);
    end

    // Blanking with an all-ones colour source
    cmode  = 0;
    cconst = 8'hFF;
    repeat (4) @(negedge clock);
    wait_px(10'd100, ok);
    check_int("von_x100", int'(bus0.video_on), 1);
`ifdef VGA_COLOR_BARS_EN
    check_int("rgb_x100", int'({bus0.red, bus0.green, bus0.blue}), 8'h03);
`else
    check_int("rgb_x100", int'({bus0.red, bus0.green, bus0.blue}), 8'hFF);
`endif
    wait_px(10'd700, ok);
    check_int("von_x700", int'(bus0.video_on), 0);
    check_int("rgb_x700", int'({bus0.red, bus0.green, bus0.blue}), 8'h00);

`ifdef VGA_COLOR_BARS_EN
    // Bars ignore a randomly toggling colour input
    cmode = 2;
    repeat (4) @(negedge clock);
    wait_px(10'd0, ok);
    check_int("bar_x000", int'({bus0.red, bus0.green, bus0.blue}), 8'h00);
    wait_px(10'd560, ok);
    check_int("bar_x560", int'({bus0.red, bus0.green, bus0.blue}), 8'hFF);
`else
    // Colour byte equal to the column: alignment checked by the scoreboard
    cmode = 1;
    repeat (1700) @(negedge clock);
`endif

    // Mid-frame reset: immediate reset values, then a fresh frame pulse
    cmode = 2;
    repeat (37) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_int("rst_px_0", int'(bus0.pixel_x), 0);
    check_int("rst_hs_0", int'(bus0.hsync), 1);
    check_int("rst_hs_1", int'(bus1.hsync), 0);
    repeat (4) @(posedge clock);
    #2 reset_n = 1'b1;
    first_fs(f0, f1);
    check_int("fs_rst_0", f0, 3);
    check_int("fs_rst_1", f1, 4);
    repeat (500) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
